// File: rtl/ipl_pkg.sv
// Shared definitions for the IPL boot-ROM overlay controller: FSM states,
// default window placement and the 64-byte boot image.
package ipl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } ipl_state_t;

    localparam logic [15:0] DEFAULT_BASE  = 16'hFFC0;
    localparam int          DEFAULT_DEPTH = 64;
    localparam int          IMAGE_BYTES   = 64;

    localparam logic [7:0] BOOT_IMAGE [IMAGE_BYTES] = '{
        8'hCD, 8'hEF, 8'hBD, 8'hE8, 8'h00, 8'hC6, 8'h1D, 8'hD0,
        8'hFC, 8'h8F, 8'hAA, 8'hF4, 8'h8F, 8'hBB, 8'hF5, 8'h78,
        8'hCC, 8'hF4, 8'hD0, 8'hFB, 8'h2F, 8'h19, 8'hEB, 8'hF4,
        8'hD0, 8'hFC, 8'h7E, 8'hF4, 8'hD0, 8'h0B, 8'hE4, 8'hF5,
        8'hCB, 8'hF4, 8'hD7, 8'h00, 8'hFC, 8'hD0, 8'hF3, 8'hAB,
        8'h01, 8'h10, 8'hEF, 8'h7E, 8'hF4, 8'h10, 8'hEB, 8'hBA,
        8'hF6, 8'hDA, 8'h00, 8'hBA, 8'hF4, 8'hC4, 8'hF4, 8'hDD,
        8'h5D, 8'hD0, 8'hDB, 8'h1F, 8'h00, 8'h00, 8'hC0, 8'hFF
    };

endpackage

// File: rtl/ipl_image.sv
// Combinational boot-image lookup; offsets past the 64-byte image read as zero
// so the window may be made larger than the image itself.
module ipl_image
    import ipl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic [$clog2(DEPTH)-1:0] offset,
    output logic [7:0]               data
);

    logic [8:0] idx;

    always_comb begin
        idx  = 9'(offset);
        data = 8'h00;
        if (idx < 9'(IMAGE_BYTES)) begin
            data = BOOT_IMAGE[idx[5:0]];
        end
    end

endmodule

// File: rtl/ipl_rom_ctrl.sv
// Boot-ROM overlay read controller with programmable latency and an $F1-style
// enable bit. Define IPL_PATCH_EN to add a writable shadow RAM over the image.
module ipl_rom_ctrl
    import ipl_pkg::*;
#(
    parameter int                ADDR_W  = 16,
    parameter int                DEPTH   = DEFAULT_DEPTH,
    parameter logic [ADDR_W-1:0] BASE    = ADDR_W'(DEFAULT_BASE),
    parameter int                LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_ack,
    output logic [7:0]        rd_data,
    output logic              rd_hit,
    input  logic [7:0]        ram_rdata,
    input  logic              ctrl_we,
    input  logic [7:0]        ctrl_wdata,
    output logic              rom_en
`ifdef IPL_PATCH_EN
    ,
    input  logic                     patch_we,
    input  logic [$clog2(DEPTH)-1:0] patch_addr,
    input  logic [7:0]               patch_wdata
`endif
);

    localparam int                OFF_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    ipl_state_t       state, state_n;
    logic [2:0]       cnt, cnt_n;
    logic             accept;
    logic [ADDR_W-1:0] addr_rel;
    logic             in_window;
    logic [OFF_W-1:0] off_q;
    logic             hit_q;
    logic [7:0]       data_q;
    logic             hit_hold;
    logic [7:0]       img_byte;
    logic [7:0]       rom_byte;
    logic [7:0]       ack_data;
    logic             ctrl_unused;

    // The subtraction only counts once rd_addr >= BASE, so no wrap can alias a hit.
    assign addr_rel    = rd_addr - BASE;
    assign in_window   = (rd_addr >= BASE) && (addr_rel < DEPTH_A);
    assign ctrl_unused = ^ctrl_wdata[6:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_req) begin
                    accept = 1'b1;
                    if (LATENCY > 1) begin
                        state_n = ST_WAIT;
                        cnt_n   = 3'(LATENCY - 1);
                    end else begin
                        state_n = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 3'd1) begin
                    state_n = ST_ACK;
                    cnt_n   = 3'd0;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            ST_ACK:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Hit is frozen at acceptance using the pre-write rom_en, so an enable
    // change while the read is in flight cannot redirect it.
    always_ff @(posedge clk) begin
        if (reset) begin
            off_q <= '0;
            hit_q <= 1'b0;
        end else if (accept) begin
            off_q <= addr_rel[OFF_W-1:0];
            hit_q <= in_window && rom_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_en <= 1'b1;
        end else if (ctrl_we) begin
            rom_en <= ctrl_wdata[7];
        end
    end

    ipl_image #(
        .DEPTH(DEPTH)
    ) u_image (
        .offset(off_q),
        .data  (img_byte)
    );

`ifdef IPL_PATCH_EN
    logic [7:0]       shadow [DEPTH];
    logic [DEPTH-1:0] valid;

    always_ff @(posedge clk) begin
        if (!reset && patch_we) begin
            shadow[patch_addr] <= patch_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (patch_we) begin
            valid[patch_addr] <= 1'b1;
        end
    end

    assign rom_byte = valid[off_q] ? shadow[off_q] : img_byte;
`else
    assign rom_byte = img_byte;
`endif

    assign ack_data = hit_q ? rom_byte : ram_rdata;

    // Data and hit are live during ACK and then held until the next ACK.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= 8'h00;
            hit_hold <= 1'b0;
        end else if (state == ST_ACK) begin
            data_q   <= ack_data;
            hit_hold <= hit_q;
        end
    end

    assign rd_ready = (state == ST_IDLE);
    assign rd_ack   = (state == ST_ACK);
    assign rd_data  = rd_ack ? ack_data : data_q;
    assign rd_hit   = rd_ack ? hit_q : hit_hold;

endmodule

// File: tb/tb_ipl_rom_ctrl.sv
// Bench for ipl_rom_ctrl: one LATENCY=1 and one LATENCY=3 instance share the
// stimulus and are checked every cycle against a transaction-level model.
module tb_ipl_rom_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [7:0]  ram_rdata;
    logic        ctrl_we;
    logic [7:0]  ctrl_wdata;

    logic [1:0]      rdy, ack, hit, ren;
    logic [1:0][7:0] data;

`ifdef IPL_PATCH_EN
    logic       patch_we;
    logic [5:0] patch_addr;
    logic [7:0] patch_wdata;
`endif

    int tests = 0;
    int fails = 0;

    localparam int LAT [2] = '{1, 3};

    byte unsigned img [64] = '{
        8'hCD, 8'hEF, 8'hBD, 8'hE8, 8'h00, 8'hC6, 8'h1D, 8'hD0,
        8'hFC, 8'h8F, 8'hAA, 8'hF4, 8'h8F, 8'hBB, 8'hF5, 8'h78,
        8'hCC, 8'hF4, 8'hD0, 8'hFB, 8'h2F, 8'h19, 8'hEB, 8'hF4,
        8'hD0, 8'hFC, 8'h7E, 8'hF4, 8'hD0, 8'h0B, 8'hE4, 8'hF5,
        8'hCB, 8'hF4, 8'hD7, 8'h00, 8'hFC, 8'hD0, 8'hF3, 8'hAB,
        8'h01, 8'h10, 8'hEF, 8'h7E, 8'hF4, 8'h10, 8'hEB, 8'hBA,
        8'hF6, 8'hDA, 8'h00, 8'hBA, 8'hF4, 8'hC4, 8'hF4, 8'hDD,
        8'h5D, 8'hD0, 8'hDB, 8'h1F, 8'h00, 8'h00, 8'hC0, 8'hFF
    };

    always #5 clk = ~clk;

    ipl_rom_ctrl #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ready(rdy[0]), .rd_ack(ack[0]), .rd_data(data[0]), .rd_hit(hit[0]),
        .ram_rdata(ram_rdata), .ctrl_we(ctrl_we), .ctrl_wdata(ctrl_wdata),
        .rom_en(ren[0])
`ifdef IPL_PATCH_EN
        , .patch_we(patch_we), .patch_addr(patch_addr), .patch_wdata(patch_wdata)
`endif
    );

    ipl_rom_ctrl #(.LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ready(rdy[1]), .rd_ack(ack[1]), .rd_data(data[1]), .rd_hit(hit[1]),
        .ram_rdata(ram_rdata), .ctrl_we(ctrl_we), .ctrl_wdata(ctrl_wdata),
        .rom_en(ren[1])
`ifdef IPL_PATCH_EN
        , .patch_we(patch_we), .patch_addr(patch_addr), .patch_wdata(patch_wdata)
`endif
    );

    // Model: each read is a pending transaction that matures LATENCY edges
    // after it is taken; an instance is free when it holds no transaction.
    bit          started = 1'b0;
    bit          m_romen;
    int          m_left [2];
    bit          m_ackc [2];
    bit          m_hit  [2];
    int          m_off  [2];
    byte unsigned m_last [2];
    int          ackCount [2] = '{0, 0};
    bit          p_valid [64];
    byte unsigned p_shadow [64];

    function automatic int romByte(input int off);
        return p_valid[off] ? int'(p_shadow[off]) : int'(img[off]);
    endfunction

    function automatic int expAckData(input int i);
        return m_hit[i] ? romByte(m_off[i]) : int'(ram_rdata);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    always @(posedge clk) begin
        int a;
        if (reset) begin
            started = 1'b1;
            m_romen = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_left[i] = 0;
                m_ackc[i] = 1'b0;
                m_last[i] = 8'h00;
            end
            for (int k = 0; k < 64; k++) p_valid[k] = 1'b0;
        end else if (started) begin
            a = int'(rd_addr);
            for (int i = 0; i < 2; i++) begin
                if (m_ackc[i]) begin
                    m_last[i] = 8'(expAckData(i));
                    m_ackc[i] = 1'b0;
                end else if (m_left[i] > 0) begin
                    m_left[i]--;
                    if (m_left[i] == 0) m_ackc[i] = 1'b1;
                end else if (rd_req) begin
                    m_hit[i]  = (a >= 'hFFC0) && (a - 'hFFC0 < 64) && m_romen;
                    m_off[i]  = (a - 'hFFC0) & 63;
                    m_left[i] = LAT[i] - 1;
                    if (m_left[i] == 0) m_ackc[i] = 1'b1;
                end
            end
`ifdef IPL_PATCH_EN
            if (patch_we) begin
                p_valid[patch_addr]  = 1'b1;
                p_shadow[patch_addr] = patch_wdata;
            end
`endif
            if (ctrl_we) m_romen = ctrl_wdata[7];
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                ackCount[i] += int'(ack[i]);
                checkOutput($sformatf("rd_ready[L%0d]", LAT[i]), int'(rdy[i]),
                            int'(m_left[i] == 0 && !m_ackc[i]));
                checkOutput($sformatf("rd_ack[L%0d]", LAT[i]), int'(ack[i]), int'(m_ackc[i]));
                checkOutput($sformatf("rom_en[L%0d]", LAT[i]), int'(ren[i]), int'(m_romen));
                checkOutput($sformatf("rd_data[L%0d]", LAT[i]), int'(data[i]),
                            m_ackc[i] ? expAckData(i) : int'(m_last[i]));
                if (m_ackc[i])
                    checkOutput($sformatf("rd_hit[L%0d]", LAT[i]), int'(hit[i]), int'(m_hit[i]));
            end
        end
    end

    // One read, accepted by both instances; returns per-instance latency
    // (negedges from the accepting edge to rd_ack), data and hit.
    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] ram,
                                 input logic we, input logic [7:0] wd,
                                 output int lat0, output int lat1,
                                 output logic [7:0] d0, output logic [7:0] d1,
                                 output logic h0, output logic h1);
        lat0 = 0; lat1 = 0; d0 = 8'h00; d1 = 8'h00; h0 = 1'b0; h1 = 1'b0;
        @(posedge clk); #1;
        rd_req = 1'b1; rd_addr = a; ram_rdata = ram; ctrl_we = we; ctrl_wdata = wd;
        @(posedge clk); #1;
        rd_req = 1'b0; ctrl_we = 1'b0;
        for (int k = 1; k <= 12 && (lat0 == 0 || lat1 == 0); k++) begin
            @(negedge clk);
            if (ack[0] && lat0 == 0) begin lat0 = k; d0 = data[0]; h0 = hit[0]; end
            if (ack[1] && lat1 == 0) begin lat1 = k; d1 = data[1]; h1 = hit[1]; end
        end
    endtask

    task automatic writeCtrl(input logic [7:0] v);
        @(posedge clk); #1;
        ctrl_we = 1'b1; ctrl_wdata = v;
        @(posedge clk); #1;
        ctrl_we = 1'b0;
    endtask

    task automatic readCheck(input string name, input logic [15:0] a, input logic [7:0] ram,
                             input int expData, input int expHit);
        int l0, l1;
        logic [7:0] d0, d1;
        logic h0, h1;
        applyStimulus(a, ram, 1'b0, 8'h00, l0, l1, d0, d1, h0, h1);
        checkOutput({name, " data L1"}, int'(d0), expData);
        checkOutput({name, " data L3"}, int'(d1), expData);
        checkOutput({name, " hit L1"}, int'(h0), expHit);
        checkOutput({name, " latency L1"}, l0, 1);
        checkOutput({name, " latency L3"}, l1, 3);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int b0, b1, l0, l1;
        logic [7:0] d0, d1;
        logic h0, h1;

        reset = 1'b1; rd_req = 1'b0; rd_addr = 16'h0000; ram_rdata = 8'h00;
        ctrl_we = 1'b0; ctrl_wdata = 8'h00;
`ifdef IPL_PATCH_EN
        patch_we = 1'b0; patch_addr = 6'h00; patch_wdata = 8'h00;
`endif
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset rd_ready", int'(rdy), 3);
        checkOutput("reset rd_ack", int'(ack), 0);
        checkOutput("reset rom_en", int'(ren), 3);
        checkOutput("reset rd_hit", int'(hit), 0);
        checkOutput("reset rd_data", int'(data), 0);

        readCheck("FFC0", 16'hFFC0, 8'h00, 'hCD, 1);
        readCheck("FFFE", 16'hFFFE, 8'h00, 'hC0, 1);
        readCheck("FFFF", 16'hFFFF, 8'h00, 'hFF, 1);
        readCheck("FFC2", 16'hFFC2, 8'h00, 'hBD, 1);

        writeCtrl(8'h00);
        readCheck("FFC0 rom off", 16'hFFC0, 8'h55, 'h55, 0);
        writeCtrl(8'h80);
        readCheck("FFC0 rom on", 16'hFFC0, 8'h55, 'hCD, 1);

        readCheck("FFBF", 16'hFFBF, 8'hA5, 'hA5, 0);
        readCheck("0000", 16'h0000, 8'hA5, 'hA5, 0);

        // Disable write coincides with acceptance: the old enable decides.
        applyStimulus(16'hFFC1, 8'h33, 1'b1, 8'h00, l0, l1, d0, d1, h0, h1);
        checkOutput("ctrl+req data L1", int'(d0), 'hEF);
        checkOutput("ctrl+req data L3", int'(d1), 'hEF);
        writeCtrl(8'h80);

        // Request held for two cycles: the second one must be swallowed.
        @(posedge clk); #1;
        b0 = ackCount[0]; b1 = ackCount[1];
        rd_req = 1'b1; rd_addr = 16'hFFC2; ram_rdata = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("held req acks L1", ackCount[0] - b0, 1);
        checkOutput("held req acks L3", ackCount[1] - b1, 1);

        // Reset one cycle after acceptance abandons the LATENCY=3 read.
        writeCtrl(8'h00);
        @(posedge clk); #1;
        rd_req = 1'b1; rd_addr = 16'hFFC0;
        @(posedge clk); #1;
        rd_req = 1'b0; reset = 1'b1;
        b1 = ackCount[1];
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post-reset rd_ready L3", int'(rdy[1]), 1);
        checkOutput("post-reset rom_en L3", int'(ren[1]), 1);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("abandoned read acks L3", ackCount[1] - b1, 0);

`ifdef IPL_PATCH_EN
        @(posedge clk); #1;
        patch_we = 1'b1; patch_addr = 6'h3F; patch_wdata = 8'h12;
        @(posedge clk); #1;
        patch_we = 1'b0;
        readCheck("patched FFFF", 16'hFFFF, 8'h00, 'h12, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        readCheck("unpatched FFFF", 16'hFFFF, 8'h00, 'hFF, 1);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
